// File: rtl/cam_host_ctrl_if.sv
// Host command/response and CAM-side signal bundle for cam_host_ctrl.
// The slave modport is the controller; master is the host/CAM environment.
interface cam_host_ctrl_if #(
  parameter int CAM_DW = 32,
  parameter int CAM_MW = 3,
  parameter int CAM_AW = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CAM_DW-1:0] cmd_data;
  logic [CAM_AW-1:0] cmd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [CAM_AW-1:0] rsp_addr;
  logic [CAM_DW-1:0] rsp_data;
  logic [CAM_DW-1:0] cam_data_in;
  logic              cam_input_valid;
  logic [CAM_AW-1:0] cam_addr_in;
  logic [CAM_MW-1:0] cam_mask_in;
  logic [CAM_MW-1:0] cam_mask_strb;
  logic              cam_mask_en;
  logic [CAM_DW-1:0] cam_data_out;
  logic [CAM_AW-1:0] cam_addr_out;
  logic              cam_hit;
  logic              cam_data_ready;
  logic              cam_data_valid;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_addr, rsp_ready,
           cam_data_out, cam_addr_out, cam_hit, cam_data_ready,
    output cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_data,
           cam_data_in, cam_input_valid, cam_addr_in, cam_mask_in,
           cam_mask_strb, cam_mask_en, cam_data_valid
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_addr, rsp_ready,
           cam_data_out, cam_addr_out, cam_hit, cam_data_ready,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_data,
           cam_data_in, cam_input_valid, cam_addr_in, cam_mask_in,
           cam_mask_strb, cam_mask_en, cam_data_valid
  );
endinterface

// File: rtl/cam_host_ctrl.sv
// Host-side controller for a CAM: sequences writes, mask updates and
// searches, and returns search hits (or timeout misses) over a valid/ready port.
module cam_host_ctrl #(
  parameter int CAM_DW  = 32,
  parameter int CAM_MW  = 3,
  parameter int CAM_AW  = 8,
  parameter int TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst,
  cam_host_ctrl_if.slave bus
);
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SETM   = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_CLRM   = 2'b11;
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SEARCH, S_CAPTURE, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_cnt;
  logic [CAM_DW-1:0] r_cam_data;
  logic [CAM_AW-1:0] r_cam_addr;
  logic [CAM_MW-1:0] r_mask, r_strb;
  logic              r_mask_en;
  logic              r_rsp_hit;
  logic [CAM_AW-1:0] r_rsp_addr;
  logic [CAM_DW-1:0] r_rsp_data;

  logic w_accept, w_busy, w_tmo, w_cap;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  assign w_busy   = (r_state == S_SEARCH) || (r_state == S_CAPTURE);
  assign w_tmo    = w_busy && (r_cnt == CNT_LAST);
  assign w_cap    = (r_state == S_CAPTURE) && bus.cam_data_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A capture landing on the timeout cycle wins over the miss.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && bus.cmd_op == OP_WRITE)  w_next = S_WRITE;
        if (w_accept && bus.cmd_op == OP_SEARCH) w_next = S_SEARCH;
      end
      S_WRITE:   w_next = S_IDLE;
      S_SEARCH: begin
        if (w_tmo)            w_next = S_RESP;
        else if (bus.cam_hit) w_next = S_CAPTURE;
      end
      S_CAPTURE: if (w_cap || w_tmo) w_next = S_RESP;
      S_RESP:    if (bus.rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_cam_data <= '0;
      r_cam_addr <= '0;
      r_mask     <= '0;
      r_strb     <= '0;
      r_mask_en  <= 1'b0;
      r_rsp_hit  <= 1'b0;
      r_rsp_addr <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_busy) r_cnt <= r_cnt + 8'd1;
      if (w_accept) begin
        case (bus.cmd_op)
          OP_WRITE: begin
            r_cam_addr <= bus.cmd_addr;
            r_cam_data <= bus.cmd_data;
          end
          OP_SETM: begin
            r_mask    <= bus.cmd_data[CAM_MW-1:0];
            r_strb    <= bus.cmd_data[2*CAM_MW-1:CAM_MW];
            r_mask_en <= 1'b1;
          end
          OP_SEARCH: begin
            r_cam_data <= bus.cmd_data;
            r_cnt      <= '0;
          end
          OP_CLRM:  r_mask_en <= 1'b0;
          default: ;
        endcase
      end
      if (w_cap) begin
        r_rsp_hit  <= 1'b1;
        r_rsp_addr <= bus.cam_addr_out;
        r_rsp_data <= bus.cam_data_out;
      end else if (w_tmo) begin
        r_rsp_hit  <= 1'b0;
        r_rsp_addr <= '0;
        r_rsp_data <= '0;
      end
    end
  end

  assign bus.cmd_ready       = (r_state == S_IDLE);
  assign bus.cam_input_valid = (r_state == S_WRITE);
  assign bus.cam_data_valid  = w_cap;
  assign bus.rsp_valid       = (r_state == S_RESP);
  assign bus.rsp_hit         = r_rsp_hit;
  assign bus.rsp_addr        = r_rsp_addr;
  assign bus.rsp_data        = r_rsp_data;
  assign bus.cam_data_in     = r_cam_data;
  assign bus.cam_addr_in     = r_cam_addr;
  assign bus.cam_mask_in     = r_mask;
  assign bus.cam_mask_strb   = r_strb;
  assign bus.cam_mask_en     = r_mask_en;
endmodule

// File: tb/tb_cam_host_ctrl.sv
// Table-driven bench for cam_host_ctrl with a response scoreboard and
// hand-written reset sequences.
module tb_cam_host_ctrl;
  localparam int DW = 32, MW = 3, AW = 8, TO = 16;
  localparam logic [1:0] OP_WR = 2'b00, OP_SM = 2'b01, OP_SR = 2'b10, OP_CM = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cam_host_ctrl_if #(.CAM_DW(DW), .CAM_MW(MW), .CAM_AW(AW)) bus();
  cam_host_ctrl #(.CAM_DW(DW), .CAM_MW(MW), .CAM_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    int            hd, rd, rr;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic          exp_hit;
    int            exp_lat;
    logic [MW-1:0] exp_mask, exp_strb;
    logic          exp_en;
  } vec_t;

  typedef struct {
    logic          hit;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rsp_t;

  vec_t tbl[12];
  rsp_t sb[$];
  rsp_t mon_e;
  int checks = 0, errors = 0, dv_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cam_data_valid) dv_cnt++;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got hit=%0b addr=0x%0h, want none", bus.rsp_hit, bus.rsp_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_rsp_hit", bus.rsp_hit, mon_e.hit);
        chk("sb_rsp_addr", bus.rsp_addr, mon_e.addr);
        chk("sb_rsp_data", bus.rsp_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish within 100us");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a);
    bus.cmd_op = op; bus.cmd_data = d; bus.cmd_addr = a; bus.cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    step();
    bus.cmd_valid = 1'b0; bus.cmd_data = $urandom; bus.cmd_addr = AW'($urandom);
  endtask

  task automatic run_search(input vec_t v);
    rsp_t e;
    int n, dv0;
    e.hit  = v.exp_hit;
    e.addr = v.exp_hit ? v.caddr : '0;
    e.data = v.exp_hit ? v.cdata : '0;
    sb.push_back(e);
    bus.cam_addr_out = v.caddr; bus.cam_data_out = v.cdata;
    bus.cam_hit = (v.hd == 0); bus.cam_data_ready = (v.hd + v.rd == 0);
    bus.rsp_ready = 1'b0;
    dv0 = dv_cnt;
    accept(OP_SR, v.data, v.addr);
    n = 1;
    while (n <= 40) begin
      bus.cam_hit = (n >= v.hd); bus.cam_data_ready = (n >= v.hd + v.rd);
      @(negedge clk);
      if (n == 1) chk("search_key", bus.cam_data_in, v.data);
      if (bus.rsp_valid) break;
      step(); n++;
    end
    chk("search_latency", n, v.exp_lat);
    for (int k = 0; k < v.rr; k++) begin
      step(); bus.cam_hit = 1'b0; bus.cam_data_ready = 1'b0;
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_cmd_ready", bus.cmd_ready, 1'b0);
      chk("hold_rsp_addr", bus.rsp_addr, e.addr);
      chk("hold_rsp_data", bus.rsp_data, e.data);
    end
    step(); bus.cam_hit = 1'b0; bus.cam_data_ready = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    step(); bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
    chk("cmd_ready_back", bus.cmd_ready, 1'b1);
    chk("cam_data_valid_pulses", dv_cnt - dv0, v.exp_hit ? 1 : 0);
    step();
  endtask

  initial begin
    bool_seen_init();
  end

  task automatic bool_seen_init();
    logic seen;
    tbl[0]  = '{OP_WR, 32'hFFFF_FFFF, 8'h01, 0, 0, 0, 8'h00, 32'h0, 1'b0, 0, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{OP_SM, 32'h0000_003F, 8'h00, 0, 0, 0, 8'h00, 32'h0, 1'b0, 0, 3'b111, 3'b111, 1'b1};
    tbl[2]  = '{OP_CM, 32'h0000_0000, 8'h00, 0, 0, 0, 8'h00, 32'h0, 1'b0, 0, 3'b111, 3'b111, 1'b0};
    tbl[3]  = '{OP_SR, 32'hFFFF_FFFF, 8'h00, 1, 0, 0, 8'h01, 32'hFFFF_FFFF, 1'b1, 3, 3'b0, 3'b0, 1'b0};
    tbl[4]  = '{OP_SR, 32'h1234_5678, 8'h00, 0, 0, 1, 8'h7E, 32'hCAFE_BABE, 1'b1, 3, 3'b0, 3'b0, 1'b0};
    tbl[5]  = '{OP_SR, 32'h0BAD_F00D, 8'h00, 4, 3, 2, 8'h33, 32'h0000_1111, 1'b1, 8, 3'b0, 3'b0, 1'b0};
    tbl[6]  = '{OP_SR, 32'hDEAD_BEEF, 8'h00, 1000, 0, 5, 8'h55, 32'h0000_5555, 1'b0, 17, 3'b0, 3'b0, 1'b0};
    tbl[7]  = '{OP_SR, 32'h0000_0F0F, 8'h00, 15, 0, 0, 8'h0F, 32'h0F0F_0F0F, 1'b1, 17, 3'b0, 3'b0, 1'b0};
    tbl[8]  = '{OP_SR, 32'h0000_1616, 8'h00, 16, 0, 0, 8'h16, 32'h1616_1616, 1'b0, 17, 3'b0, 3'b0, 1'b0};
    tbl[9]  = '{OP_SR, 32'h0000_1017, 8'h00, 10, 7, 1, 8'h10, 32'h1010_1010, 1'b0, 17, 3'b0, 3'b0, 1'b0};
    tbl[10] = '{OP_WR, 32'hA5A5_0F0F, 8'hFE, 0, 0, 0, 8'h00, 32'h0, 1'b0, 0, 3'b000, 3'b000, 1'b0};
    tbl[11] = '{OP_SM, 32'h0000_0015, 8'h00, 0, 0, 0, 8'h00, 32'h0, 1'b0, 0, 3'b101, 3'b010, 1'b1};

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0; bus.cmd_addr = '0;
    bus.rsp_ready = 1'b0; bus.cam_data_out = '0; bus.cam_addr_out = '0;
    bus.cam_hit = 1'b0; bus.cam_data_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_input_valid", bus.cam_input_valid, 1'b0);
    chk("rst_mask_en", bus.cam_mask_en, 1'b0);
    chk("rst_cam_data_in", bus.cam_data_in, '0);
    chk("rst_rsp_hit", bus.rsp_hit, 1'b0);
    step(); rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      case (tbl[i].op)
        OP_WR: begin
          accept(OP_WR, tbl[i].data, tbl[i].addr);
          @(negedge clk);
          chk("wr_input_valid", bus.cam_input_valid, 1'b1);
          chk("wr_addr", bus.cam_addr_in, tbl[i].addr);
          chk("wr_data", bus.cam_data_in, tbl[i].data);
          chk("wr_cmd_ready", bus.cmd_ready, 1'b0);
          step();
          @(negedge clk);
          chk("wr_input_valid_off", bus.cam_input_valid, 1'b0);
          chk("wr_idle", bus.cmd_ready, 1'b1);
          step();
        end
        OP_SM, OP_CM: begin
          accept(tbl[i].op, tbl[i].data, tbl[i].addr);
          @(negedge clk);
          chk("mask_en", bus.cam_mask_en, tbl[i].exp_en);
          chk("mask_in", bus.cam_mask_in, tbl[i].exp_mask);
          chk("mask_strb", bus.cam_mask_strb, tbl[i].exp_strb);
          step();
        end
        default: run_search(tbl[i]);
      endcase
    end

    // Reset while searching: no response may ever appear, mask enable drops.
    accept(OP_SR, 32'h7777_7777, 8'h00);
    step(); step(); step();
    rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_search_idle", bus.cmd_ready, 1'b1);
    chk("rst_search_mask_en", bus.cam_mask_en, 1'b0);
    chk("rst_search_key", bus.cam_data_in, '0);
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < TO + 4; k++) begin
      step(); @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst_search_no_rsp", seen, 1'b0);
    step(); bus.rsp_ready = 1'b0;

    // Reset while holding a response: it is dropped, not delivered.
    bus.cam_addr_out = 8'h44; bus.cam_data_out = 32'h4444_4444;
    bus.cam_hit = 1'b1; bus.cam_data_ready = 1'b1;
    accept(OP_SR, 32'h4444_4444, 8'h00);
    step(); step();
    @(negedge clk);
    chk("pre_rst_rsp_valid", bus.rsp_valid, 1'b1);
    step(); rst = 1'b1; bus.cam_hit = 1'b0; bus.cam_data_ready = 1'b0;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", bus.rsp_valid, 1'b0);
    chk("rst_resp_hit", bus.rsp_hit, 1'b0);
    chk("rst_resp_addr", bus.rsp_addr, '0);
    chk("rst_resp_ready", bus.cmd_ready, 1'b1);
    step();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask
endmodule
